alu_issue_unit: RTL and testbench

Issue/capture stage wrapped directly around the clocked ALU. It accepts one operation request (opcode plus two 16-bit operands) over a valid/ready handshake, drives the ALU `In_1`, `In_2` and `ALUOp` inputs, and holds them stable for the ALU latency. It then captures `ALUOut`, `Z` and `Y` and presents them to writeback over a second valid/ready handshake. Reserved opcodes are rejected without issuing to the ALU.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_issue_unit.sv | 130 +++++++++++++
 tb/tb_alu_issue_unit.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the issue/capture stage that wraps it:
// opcode encodings, opcode legality, and the issue FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_OP_W  = 4;

  // Opcode 0 is NOP; 6 and 9..15 are reserved.
  localparam logic [ALU_OP_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP1 = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP2 = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP3 = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_OP4 = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_OP5 = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OP7 = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OP8 = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } issue_state_t;

  // True for opcodes that the ALU actually implements.
  function automatic logic alu_op_valid(input logic [ALU_OP_W-1:0] op);
    case (op)
      ALU_OP1, ALU_OP2, ALU_OP3, ALU_OP4,
      ALU_OP5, ALU_OP7, ALU_OP8: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_unit.sv
// Issue/capture stage around the clocked ALU. Accepts one request over a
// valid/ready handshake, holds the ALU inputs stable for ALU_LAT cycles,
// captures the ALU result and flags, and hands them to writeback over a
// second valid/ready handshake. Reserved opcodes never reach the ALU and
// come back as an error result.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OP_W    = ALU_OP_W,
  parameter int ALU_LAT = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  // ALU side
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_z,
  input  logic             alu_y,
  // writeback side
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_z,
  output logic             res_y,
  output logic             res_err,
  output logic [15:0]      issue_count
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  issue_state_t     state;
  logic [CNT_W-1:0] lat_cnt;
  logic             pend_err;  // operation in EXEC is a rejected opcode
  logic             accept;
  logic             op_ok;

  // Ready is decoded from state so DONE can retire and accept on one edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    req_ready = 1'b0;
    case (state)
      IDLE:    req_ready = 1'b1;
      DONE:    req_ready = res_ready;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;
  assign op_ok  = alu_op_valid(req_op);

  // Issue FSM, latency counter, ALU drive, result capture and issue counter.
  // A reserved opcode spends one cycle in EXEC (counter loaded with 0) so its
  // error result appears one edge after accept; it never drives alu_op.
  // NOTE: the reset branch is asynchronous (in the sensitivity list) and all
  // state updates use non-blocking assignments so every register samples
  // pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      pend_err    <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_op      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_z       <= 1'b0;
      res_y       <= 1'b0;
      res_err     <= 1'b0;
      issue_count <= '0;
    end else begin
      case (state)
        EXEC: begin
          if (lat_cnt == '0) begin
            state     <= DONE;
            res_valid <= 1'b1;
            alu_op    <= '0;
            if (pend_err) begin
              res_data <= '0;
              res_z    <= 1'b0;
              res_y    <= 1'b0;
              res_err  <= 1'b1;
            end else begin
              res_data <= alu_out;
              res_z    <= alu_z;
              res_y    <= alu_y;
              res_err  <= 1'b0;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept from IDLE or as a DONE fall-through; overrides the retire above.
      if (accept) begin
        state    <= EXEC;
        pend_err <= ~op_ok;
        if (op_ok) begin
          alu_in1     <= req_a;
          alu_in2     <= req_b;
          alu_op      <= req_op;
          lat_cnt     <= CNT_W'(ALU_LAT);
          issue_count <= (issue_count == 16'hFFFF) ? issue_count
                                                   : issue_count + 16'd1;
        end else begin
          lat_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit. A behavioural ALU (one-cycle latency)
// sits on the ALU ports; stimulus pushes hand-computed results into a queue
// and a separate monitor pops and compares on every result handshake.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_op;
  logic        alu_z, alu_y;
  logic        res_valid, res_ready;
  logic [15:0] res_data;
  logic        res_z, res_y, res_err;
  logic [15:0] issue_count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [18:0] exp_q[$];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  alu_issue_unit #(.WIDTH(16), .OP_W(4), .ALU_LAT(1)) dut (
    .Clock(Clock), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_y(alu_y),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_z(res_z), .res_y(res_y), .res_err(res_err),
    .issue_count(issue_count)
  );

  // Behavioural ALU: add(1) sub(2) and(3) or(4) xor(5) shl(7) shr(8).
  // Y is carry (add) / borrow (sub); Z flags a zero result.
  function automatic logic [17:0] alu_model(input logic [15:0] a, b, input logic [3:0] op);
    logic [16:0] r;
    r = '0;
    case (op)
      4'd1: r = {1'b0, a} + {1'b0, b};
      4'd2: r = {1'b0, a} - {1'b0, b};
      4'd3: r = {1'b0, a & b};
      4'd4: r = {1'b0, a | b};
      4'd5: r = {1'b0, a ^ b};
      4'd7: r = {1'b0, a << b[3:0]};
      4'd8: r = {1'b0, a >> b[3:0]};
      default: r = '0;
    endcase
    return {r[16], (r[15:0] == 16'd0), r[15:0]};
  endfunction

  always @(posedge Clock) {alu_y, alu_z, alu_out} <= alu_model(alu_in1, alu_in2, alu_op);

  function automatic logic [18:0] pk(input logic [15:0] d, input logic z, y, e);
    return {e, y, z, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed result handshake is scored against the queue.
  initial begin
    logic [18:0] e;
    forever begin
      @(negedge Clock);
      if (!Reset && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {13'd0, res_err, res_y, res_z, res_data}, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("result", {13'd0, res_err, res_y, res_z, res_data}, {13'd0, e});
        end
      end
    end
  end

  // Present a request and wait (bounded) for the accept edge; returns #1 after it.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, b,
                       input logic [18:0] exp, input bit keep);
    int n;
    n = 0;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge Clock);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge Clock);
    end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge Clock);
      #1;
      exp_q.push_back(exp);
      if (!keep) begin
        req_valid = 1'b0;
        req_a = 16'hBEEF; req_b = 16'hF00D; req_op = 4'd3;
      end
    end
  endtask

  // Bounded wait until res_valid is seen at a falling edge.
  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge Clock);
    while (!res_valid && n < 50) begin
      n++;
      @(negedge Clock);
    end
    if (!res_valid) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [3:0]  bp_op [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8};
  logic [15:0] bp_a  [7] = '{16'hFFFF, 16'h0003, 16'hF0F0, 16'h1200, 16'hAAAA, 16'h0001, 16'h8000};
  logic [15:0] bp_b  [7] = '{16'h0001, 16'h0005, 16'h0FF0, 16'h0034, 16'hAAAA, 16'h0004, 16'h000F};
  logic [18:0] bp_e  [7];

  initial begin
    int a1, a2, a3;
    bp_e[0] = pk(16'h0000, 1'b1, 1'b1, 1'b0);
    bp_e[1] = pk(16'hFFFE, 1'b0, 1'b1, 1'b0);
    bp_e[2] = pk(16'h00F0, 1'b0, 1'b0, 1'b0);
    bp_e[3] = pk(16'h1234, 1'b0, 1'b0, 1'b0);
    bp_e[4] = pk(16'h0000, 1'b1, 1'b0, 1'b0);
    bp_e[5] = pk(16'h0010, 1'b0, 1'b0, 1'b0);
    bp_e[6] = pk(16'h0001, 1'b0, 1'b0, 1'b0);

    Reset = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;

    // Reset state
    #2;
    check("rst_req_ready", req_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_alu", {alu_in1, alu_in2, 12'd0, alu_op}, 0);
    check("rst_res", {res_data, res_z, res_y}, 0);
    check("rst_issue_count", issue_count, 0);
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    // Single op: 5 + 3
    res_ready = 1'b1;
    issue(4'd1, 16'd5, 16'd3, pk(16'd8, 1'b0, 1'b0, 1'b0), 1'b0);
    check("single_alu_in1", alu_in1, 5);
    check("single_alu_in2", alu_in2, 3);
    check("single_alu_op", alu_op, 1);
    check("single_issue_count", issue_count, 1);
    @(negedge Clock); check("single_valid_c0", res_valid, 0);
    @(negedge Clock); check("single_valid_c1", res_valid, 0);
    @(negedge Clock); check("single_valid_c2", res_valid, 1);
    check("single_alu_op_nop", alu_op, 0);
    @(posedge Clock); #1;

    // Reserved op 6
    issue(4'd6, 16'h1111, 16'h2222, pk(16'd0, 1'b0, 1'b0, 1'b1), 1'b0);
    check("resv_alu_op", alu_op, 0);
    check("resv_issue_count", issue_count, 1);
    @(negedge Clock);
    check("resv_valid_c0", res_valid, 0);
    check("resv_req_ready_exec", req_ready, 0);
    @(negedge Clock);
    check("resv_valid_c1", res_valid, 1);
    check("resv_err", res_err, 1);
    check("resv_data", res_data, 0);
    check("resv_alu_op_held", alu_op, 0);
    @(posedge Clock); #1;

    // Reset in the middle of EXEC
    issue(4'd2, 16'd9, 16'd4, pk(16'd5, 1'b0, 1'b0, 1'b0), 1'b0);
    @(posedge Clock); #1;
    check("midrst_in_exec", alu_op, 2);
    Reset = 1'b1;
    #1;
    check("midrst_res_valid", res_valid, 0);
    check("midrst_alu", {alu_in1, alu_in2, 12'd0, alu_op}, 0);
    check("midrst_res", {13'd0, res_err, res_z, res_y, res_data}, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_issue_count", issue_count, 0);
    exp_q.delete();
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      check("midrst_no_result", res_valid, 0);
    end
    @(posedge Clock); #1;

    // Backpressure: every valid opcode, result held 5 cycles
    res_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      issue(bp_op[i], bp_a[i], bp_b[i], bp_e[i], 1'b0);
      wait_valid();
      for (int c = 0; c < 5; c++) begin
        check("bp_valid", res_valid, 1);
        check("bp_req_ready", req_ready, 0);
        check("bp_stable", {13'd0, res_err, res_y, res_z, res_data}, {13'd0, bp_e[i]});
        @(negedge Clock);
      end
      @(posedge Clock); #1;
      res_ready = 1'b1;
      @(negedge Clock);
      check("bp_req_ready_follows", req_ready, 1);
      @(posedge Clock); #1;
      res_ready = 1'b0;
    end
    check("bp_issue_count", issue_count, 7);

    // Fall-through: accept on every DONE edge, one result per 3 cycles
    res_ready = 1'b1;
    issue(4'd1, 16'd10, 16'd20, pk(16'h001E, 1'b0, 1'b0, 1'b0), 1'b1);
    a1 = cyc;
    issue(4'd2, 16'd100, 16'd1, pk(16'h0063, 1'b0, 1'b0, 1'b0), 1'b1);
    a2 = cyc;
    issue(4'd3, 16'h00FF, 16'h0F0F, pk(16'h000F, 1'b0, 1'b0, 1'b0), 1'b0);
    a3 = cyc;
    check("ft_spacing_1", a2 - a1, 3);
    check("ft_spacing_2", a3 - a2, 3);
    wait_valid();
    @(posedge Clock); #1;
    check("ft_issue_count", issue_count, 10);

    // Saturation: counter preset to FFFE, three more valid ops
    force dut.issue_count = 16'hFFFE;
    issue(4'd4, 16'h0F00, 16'h00F0, pk(16'h0FF0, 1'b0, 1'b0, 1'b0), 1'b0);
    release dut.issue_count;
    wait_valid();
    @(posedge Clock); #1;
    issue(4'd5, 16'hFFFF, 16'h00FF, pk(16'hFF00, 1'b0, 1'b0, 1'b0), 1'b0);
    wait_valid();
    @(posedge Clock); #1;
    issue(4'd7, 16'h0003, 16'h0001, pk(16'h0006, 1'b0, 1'b0, 1'b0), 1'b0);
    wait_valid();
    @(posedge Clock); #1;
    check("sat_issue_count", issue_count, 16'hFFFF);

    repeat (3) @(posedge Clock);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
